// File: rtl/gcd_requester_pkg.sv
// Shared definitions for the GCD requester: FSM encoding, default sizing and
// the timeout counter width helper.
package gcd_requester_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_W       = 5;
    localparam int unsigned DEF_TIMEOUT = 63;

    function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int unsigned DEF_TMO_CNT_W = tmo_cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/gcd_requester.sv
// Client-side requester for a GCD engine: accepts an operand pair, bypasses
// trivial pairs, starts the engine, waits with timeout and returns the result.
//
// state   | meaning
// IDLE    | ready for a new operand pair
// START   | one-cycle Go pulse to the engine
// WAIT    | waiting for engine Done or timeout
// RESP    | result held for client handshake
module gcd_requester
    import gcd_requester_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_x_i,
    input  logic [W-1:0] in_y_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         go_o,
    input  logic         done_i,
    input  logic [W-1:0] result_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_gcd_o,
    output logic         out_err_o,
    output logic [7:0]   count_o
);

    localparam int unsigned CW = tmo_cnt_w(TIMEOUT);
    // The TIMEOUT-th WAIT cycle is the last one in which Done is still honoured.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [W-1:0]  gcd_q, gcd_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    x_d = in_x_i;
                    y_d = in_y_i;
                    if (in_x_i != '0 && in_y_i != '0) begin
                        state_d = S_START;
                    end else begin
                        // With at least one zero operand the OR is the answer.
                        gcd_d   = in_x_i | in_y_i;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_i) begin
                    gcd_d   = result_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (out_ready_i) begin
                    count_d = count_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign go_o        = (state_q == S_START);
    assign out_valid_o = (state_q == S_RESP);
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign out_gcd_o   = gcd_q;
    assign out_err_o   = err_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Randomized bench for gcd_requester with a cycle-count reference model of
// the transaction outcome and a behavioural GCD engine.
module tb_gcd_requester;

    localparam int W       = 5;
    localparam int TIMEOUT = 63;
    localparam int NEVER   = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_x_i, in_y_i;
    logic [W-1:0] x_o, y_o;
    logic         go_o;
    logic         done_i;
    logic [W-1:0] result_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_gcd_o;
    logic         out_err_o;
    logic [7:0]   count_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_count = 8'd0;

    gcd_requester #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .in_y_i      (in_y_i),
        .x_o         (x_o),
        .y_o         (y_o),
        .go_o        (go_o),
        .done_i      (done_i),
        .result_i    (result_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_gcd_o   (out_gcd_o),
        .out_err_o   (out_err_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Runs one transaction starting at a negedge in IDLE. d is the number of
    // WAIT cycles after Go before the engine raises Done; stall is the number
    // of RESP cycles the client withholds Out_Ready.
    task automatic do_txn(input int x, input int y, input int d, input int stall);
        bit bypass;
        int g, exp_gcd, exp_err, exp_c, c, gos;
        bit got;
        bypass  = (x == 0) || (y == 0);
        g       = bypass ? (x | y) : ref_gcd(x, y);
        exp_gcd = (bypass || d <= TIMEOUT) ? g : 0;
        exp_err = (!bypass && d > TIMEOUT) ? 1 : 0;
        exp_c   = bypass ? 1 : ((d <= TIMEOUT) ? d + 2 : TIMEOUT + 2);

        check_eq("in_ready_idle", in_ready_o, 1);
        in_valid_i  = 1'b1;
        in_x_i      = W'(x);
        in_y_i      = W'(y);
        done_i      = 1'($urandom_range(0, 1));
        result_i    = W'($urandom);
        out_ready_i = 1'($urandom_range(0, 1));
        c = 0; gos = 0; got = 0;
        while (!got && c < 200) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            in_valid_i = 1'b0;
            in_x_i     = W'($urandom);
            in_y_i     = W'($urandom);
            if (go_o) gos++;
            if (out_valid_o) begin
                got = 1;
                out_ready_i = 1'b0;
            end else begin
                check_eq("x_hold", x_o, x);
                check_eq("y_hold", y_o, y);
                out_ready_i = 1'($urandom_range(0, 1));
                if (c == 1) done_i = 1'($urandom_range(0, 1));
                else        done_i = ((c - 1) >= d);
                result_i = done_i && c > 1 ? W'(g) : W'($urandom);
            end
        end
        check_eq("valid_seen", got, 1);
        check_eq("latency", c, exp_c);
        check_eq("go_pulses", gos, bypass ? 0 : 1);
        check_eq("out_gcd", out_gcd_o, exp_gcd);
        check_eq("out_err", out_err_o, exp_err);
        check_eq("in_ready_resp", in_ready_o, 0);

        for (int i = 0; i < stall; i++) begin
            done_i   = 1'($urandom_range(0, 1));
            result_i = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_valid", out_valid_o, 1);
            check_eq("stall_gcd", out_gcd_o, exp_gcd);
            check_eq("stall_err", out_err_o, exp_err);
            check_eq("stall_ready", in_ready_o, 0);
            check_eq("stall_count", count_o, exp_count);
        end

        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_i = 1'b0;
        done_i      = 1'b0;
        exp_count   = exp_count + 8'd1;
        check_eq("count", count_o, exp_count);
        check_eq("valid_after_hs", out_valid_o, 0);
        check_eq("ready_after_hs", in_ready_o, 1);
    endtask

    initial begin
        int x, y, d;
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_x_i      = '0;
        in_y_i      = '0;
        done_i      = 1'b0;
        result_i    = '0;
        out_ready_i = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready_o, 1);
        check_eq("rst_go", go_o, 0);
        check_eq("rst_valid", out_valid_o, 0);
        check_eq("rst_err", out_err_o, 0);
        check_eq("rst_gcd", out_gcd_o, 0);
        check_eq("rst_x", x_o, 0);
        check_eq("rst_y", y_o, 0);
        check_eq("rst_count", count_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(12, 18, 4, 0);
        do_txn(0, 7, 0, 0);
        do_txn(0, 0, 0, 0);
        do_txn(9, 6, NEVER, 0);
        do_txn(20, 15, TIMEOUT, 0);
        do_txn(20, 15, TIMEOUT + 1, 0);
        do_txn(21, 14, TIMEOUT - 1, 0);
        do_txn(31, 17, 2, 10);
        do_txn(5, 0, 0, 10);

        for (int t = 0; t < 40; t++) begin
            x = $urandom_range(0, 31);
            y = $urandom_range(0, 31);
            d = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, TIMEOUT + 3);
            do_txn(x, y, d, $urandom_range(0, 3));
        end

        // Reset in the middle of a WAIT: transaction is abandoned.
        in_valid_i = 1'b1;
        in_x_i     = W'(9);
        in_y_i     = W'(6);
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_wait", in_ready_o, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", in_ready_o, 1);
        check_eq("arst_go", go_o, 0);
        check_eq("arst_valid", out_valid_o, 0);
        check_eq("arst_x", x_o, 0);
        check_eq("arst_y", y_o, 0);
        check_eq("arst_count", count_o, 0);
        exp_count = 8'd0;
        @(negedge clk);
        rst_n  = 1'b1;
        done_i = 1'b1;
        result_i = W'(3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("post_rst_idle", in_ready_o, 1);
            check_eq("post_rst_valid", out_valid_o, 0);
            check_eq("post_rst_go", go_o, 0);
        end
        done_i = 1'b0;

        for (int t = 0; t < 256; t++) begin
            x = $urandom_range(0, 31);
            if (t % 2 == 0) do_txn(x, 0, 0, 0);
            else            do_txn(0, x, 0, 0);
        end
        check_eq("count_wrap", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
